load_store_sequencer: RTL and testbench



---
 rtl/lsu_pkg.sv | 35 +++
 rtl/load_extend.sv | 20 ++
 rtl/load_store_sequencer.sv | 134 +++++++++++++
 tb/tb_load_store_sequencer.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared access-mode encodings, FSM state type and mode decode helpers for the
// load/store sequencer.
package lsu_pkg;

   localparam logic [2:0] MODE_LB  = 3'b000;
   localparam logic [2:0] MODE_LH  = 3'b001;
   localparam logic [2:0] MODE_LW  = 3'b010;
   localparam logic [2:0] MODE_LBU = 3'b011;
   localparam logic [2:0] MODE_LHU = 3'b100;
   localparam logic [2:0] MODE_SB  = 3'b101;
   localparam logic [2:0] MODE_SH  = 3'b110;
   localparam logic [2:0] MODE_SW  = 3'b111;

   typedef enum logic {
      IDLE  = 1'b0,
      SPLIT = 1'b1
   } lsu_state_t;

   function automatic logic [2:0] mode_size(input logic [2:0] mode);
      case (mode)
         MODE_LB, MODE_LBU, MODE_SB: mode_size = 3'd1;
         MODE_LH, MODE_LHU, MODE_SH: mode_size = 3'd2;
         default:                    mode_size = 3'd4;
      endcase
   endfunction

   function automatic logic mode_is_signed(input logic [2:0] mode);
      mode_is_signed = (mode == MODE_LB) || (mode == MODE_LH);
   endfunction

   function automatic logic mode_is_store(input logic [2:0] mode);
      mode_is_store = (mode == MODE_SB) || (mode == MODE_SH) || (mode == MODE_SW);
   endfunction

endpackage

// File: rtl/load_extend.sv
// Trims an assembled little-endian load to its access size and sign- or
// zero-extends it to the full data width.
module load_extend #(
   parameter int Width = 32
) (
   input  logic [2:0]       size,
   input  logic             is_signed,
   input  logic [Width-1:0] raw,
   output logic [Width-1:0] extended
);

   always_comb begin
      case (size)
         3'd1:    extended = {{(Width-8){is_signed & raw[7]}}, raw[7:0]};
         3'd2:    extended = {{(Width-16){is_signed & raw[15]}}, raw[15:0]};
         default: extended = raw;
      endcase
   end

endmodule

// File: rtl/load_store_sequencer.sv
// Core-side memory port sequencer: aligned accesses pass through, misaligned
// halfword/word accesses are split into byte accesses while the core stalls.
//
// state | meaning
// IDLE  | pass-through, or issue byte 0 of a misaligned access
// SPLIT | issuing bytes 1..last of a misaligned access
module load_store_sequencer
   import lsu_pkg::*;
#(
   parameter int Width    = 32,
   parameter int MemBytes = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_read,
   input  logic             req_write,
   input  logic [2:0]       req_mode,
   input  logic [Width-1:0] req_addr,
   input  logic [Width-1:0] req_wdata,
   input  logic [Width-1:0] mem_rdata,
   output logic [Width-1:0] mem_addr,
   output logic [Width-1:0] mem_wdata,
   output logic [2:0]       mem_mode,
   output logic             mem_write,
   output logic             mem_read,
   output logic [Width-1:0] load_data,
   output logic             stall,
   output logic             access_fault,
   output logic [15:0]      misalign_count
);

   lsu_state_t       state, state_nxt;
   logic [1:0]       byte_idx, byte_idx_nxt;
   logic [23:0]      assembled, assembled_nxt;
   logic             count_inc;

   logic [2:0]       size;
   logic [1:0]       last_idx;
   logic             access, is_store, misaligned, fault, split_active;
   logic [Width:0]   end_addr;
   logic [1:0]       k;
   logic [7:0]       wbyte;
   logic [Width-1:0] raw, extended;

   assign size       = mode_size(req_mode);
   assign last_idx   = 2'(size - 3'd1);
   assign access     = req_read | req_write;
   assign is_store   = req_write;
   assign misaligned = ((size == 3'd2) && req_addr[0]) ||
                       ((size == 3'd4) && (req_addr[1:0] != 2'b00));
   // One extra bit so an access wrapping past the top of the address space faults.
   assign end_addr   = {1'b0, req_addr} + (Width+1)'(size) - (Width+1)'(1);
   assign fault      = access && (end_addr >= (Width+1)'(MemBytes));

   assign split_active = (state == SPLIT) || (access && misaligned && !fault);
   assign k            = (state == SPLIT) ? byte_idx : 2'd0;
   assign wbyte        = req_wdata[{k, 3'b000} +: 8];

   always_comb begin
      raw = '0;
      raw[23:0] = assembled;
      raw[{last_idx, 3'b000} +: 8] = mem_rdata[7:0];
   end

   load_extend #(.Width(Width)) u_load_extend (
      .size      (size),
      .is_signed (mode_is_signed(req_mode)),
      .raw       (raw),
      .extended  (extended)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= IDLE;
         byte_idx       <= 2'd0;
         assembled      <= '0;
         misalign_count <= '0;
      end else begin
         state     <= state_nxt;
         byte_idx  <= byte_idx_nxt;
         assembled <= assembled_nxt;
         if (count_inc && (misalign_count != 16'hFFFF))
            misalign_count <= misalign_count + 16'd1;
      end
   end

   always_comb begin
      state_nxt     = state;
      byte_idx_nxt  = byte_idx;
      assembled_nxt = assembled;
      count_inc     = 1'b0;
      mem_addr      = req_addr;
      mem_wdata     = req_wdata;
      mem_mode      = req_mode;
      mem_write     = req_write;
      mem_read      = req_read & ~req_write;
      load_data     = req_write ? '0 : mem_rdata;
      stall         = 1'b0;
      access_fault  = 1'b0;

      if (state == IDLE && fault) begin
         access_fault = 1'b1;
         mem_read     = 1'b0;
         mem_write    = 1'b0;
         load_data    = '0;
      end else if (split_active) begin
         mem_addr  = req_addr + Width'(k);
         mem_mode  = is_store ? MODE_SB : MODE_LBU;
         mem_wdata = Width'(wbyte);
         mem_write = is_store;
         mem_read  = ~is_store;
         load_data = '0;
         if (state == SPLIT && k == last_idx) begin
            if (!is_store)
               load_data = extended;
            count_inc    = 1'b1;
            byte_idx_nxt = 2'd0;
            state_nxt    = IDLE;
         end else begin
            stall = 1'b1;
            if (!is_store) begin
               case (k)
                  2'd0:    assembled_nxt[7:0]   = mem_rdata[7:0];
                  2'd1:    assembled_nxt[15:8]  = mem_rdata[7:0];
                  default: assembled_nxt[23:16] = mem_rdata[7:0];
               endcase
            end
            byte_idx_nxt = k + 2'd1;
            state_nxt    = SPLIT;
         end
      end
   end

endmodule

// File: tb/tb_load_store_sequencer.sv
// Directed bench for load_store_sequencer with a 32-byte little-endian memory model.
module tb_load_store_sequencer;
   import lsu_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_read, req_write;
   logic [2:0]  req_mode;
   logic [31:0] req_addr, req_wdata;
   logic [31:0] mem_rdata, mem_addr, mem_wdata, load_data;
   logic [2:0]  mem_mode;
   logic        mem_write, mem_read, stall, access_fault;
   logic [15:0] misalign_count;

   logic [7:0]  mem [32];
   logic        mem_clear;
   logic [4:0]  ma;
   logic [31:0] mw;
   logic        in_range;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   load_store_sequencer #(.Width(32), .MemBytes(32)) dut (
      .clk(clk), .reset(reset),
      .req_read(req_read), .req_write(req_write), .req_mode(req_mode),
      .req_addr(req_addr), .req_wdata(req_wdata), .mem_rdata(mem_rdata),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_mode(mem_mode),
      .mem_write(mem_write), .mem_read(mem_read), .load_data(load_data),
      .stall(stall), .access_fault(access_fault), .misalign_count(misalign_count)
   );

   // Memory model: combinational, already-extending reads; byte-lane writes on clk.
   assign ma       = mem_addr[4:0];
   assign in_range = (mem_addr < 32'd32);
   assign mw       = {mem[ma + 5'd3], mem[ma + 5'd2], mem[ma + 5'd1], mem[ma]};

   always_comb begin
      mem_rdata = 32'h0;
      if (in_range) begin
         case (mem_mode)
            MODE_LB:  mem_rdata = {{24{mw[7]}}, mw[7:0]};
            MODE_LBU: mem_rdata = {24'h0, mw[7:0]};
            MODE_LH:  mem_rdata = {{16{mw[15]}}, mw[15:0]};
            MODE_LHU: mem_rdata = {16'h0, mw[15:0]};
            default:  mem_rdata = mw;
         endcase
      end
   end

   always @(posedge clk) begin
      if (mem_clear) begin
         for (int i = 0; i < 32; i++) mem[i] <= 8'h00;
      end else if (mem_write && in_range) begin
         mem[ma] <= mem_wdata[7:0];
         if (mem_mode == MODE_SH || mem_mode == MODE_SW) mem[ma + 5'd1] <= mem_wdata[15:8];
         if (mem_mode == MODE_SW) begin
            mem[ma + 5'd2] <= mem_wdata[23:16];
            mem[ma + 5'd3] <= mem_wdata[31:24];
         end
      end
   end

   typedef struct {
      logic        rd;
      logic        wr;
      logic [2:0]  mode;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        chk_ld;
      logic [31:0] exp_ld;
      logic        exp_fault;
      logic        exp_rd;
      logic        exp_wr;
   } vec_t;

   vec_t vecs[14];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic rd, input logic wr, input logic [2:0] mode,
                        input logic [31:0] addr, input logic [31:0] wdata);
      req_read  = rd;
      req_write = wr;
      req_mode  = mode;
      req_addr  = addr;
      req_wdata = wdata;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, MODE_LB, 32'h0, 32'h0);
   endtask

   task automatic single(input logic rd, input logic wr, input logic [2:0] mode,
                         input logic [31:0] addr, input logic [31:0] wdata);
      drive(rd, wr, mode, addr, wdata);
      @(posedge clk); #1;
      idle();
   endtask

   task automatic run_split(input logic rd, input logic wr, input logic [2:0] mode,
                            input logic [31:0] addr, input logic [31:0] wdata, input int n,
                            input logic chk_ld, input logic [31:0] exp_ld, input string nm);
      drive(rd, wr, mode, addr, wdata);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         chk({nm, " stall"}, 32'(stall), (i < n - 1) ? 32'd1 : 32'd0);
         chk({nm, " mem_addr"}, mem_addr, addr + 32'(i));
         chk({nm, " mem_mode"}, 32'(mem_mode), wr ? 32'(MODE_SB) : 32'(MODE_LBU));
         if (i == n - 1 && chk_ld) chk({nm, " load_data"}, load_data, exp_ld);
         @(posedge clk); #1;
      end
      idle();
   endtask

   initial begin
      vecs[0]  = '{1'b0, 1'b1, MODE_SW,  32'h04,       32'hDEADBEEF, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1};
      vecs[1]  = '{1'b1, 1'b0, MODE_LW,  32'h04,       32'h0,        1'b1, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0};
      vecs[2]  = '{1'b1, 1'b0, MODE_LB,  32'h04,       32'h0,        1'b1, 32'hFFFFFFEF, 1'b0, 1'b1, 1'b0};
      vecs[3]  = '{1'b1, 1'b0, MODE_LBU, 32'h07,       32'h0,        1'b1, 32'h000000DE, 1'b0, 1'b1, 1'b0};
      vecs[4]  = '{1'b1, 1'b0, MODE_LH,  32'h06,       32'h0,        1'b1, 32'hFFFFDEAD, 1'b0, 1'b1, 1'b0};
      vecs[5]  = '{1'b1, 1'b0, MODE_LHU, 32'h04,       32'h0,        1'b1, 32'h0000BEEF, 1'b0, 1'b1, 1'b0};
      vecs[6]  = '{1'b1, 1'b0, MODE_LW,  32'h1E,       32'h0,        1'b1, 32'h0,        1'b1, 1'b0, 1'b0};
      vecs[7]  = '{1'b1, 1'b0, MODE_LW,  32'hFFFFFFFE, 32'h0,        1'b1, 32'h0,        1'b1, 1'b0, 1'b0};
      vecs[8]  = '{1'b0, 1'b1, MODE_SB,  32'h1F,       32'h0000005A, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1};
      vecs[9]  = '{1'b1, 1'b0, MODE_LH,  32'h1F,       32'h0,        1'b1, 32'h0,        1'b1, 1'b0, 1'b0};
      vecs[10] = '{1'b1, 1'b0, MODE_LB,  32'h20,       32'h0,        1'b1, 32'h0,        1'b1, 1'b0, 1'b0};
      vecs[11] = '{1'b1, 1'b1, MODE_SW,  32'h0C,       32'h01020304, 1'b1, 32'h0,        1'b0, 1'b0, 1'b1};
      vecs[12] = '{1'b1, 1'b0, MODE_LW,  32'h0C,       32'h0,        1'b1, 32'h01020304, 1'b0, 1'b1, 1'b0};
      vecs[13] = '{1'b1, 1'b0, MODE_LBU, 32'h1F,       32'h0,        1'b1, 32'h0000005A, 1'b0, 1'b1, 1'b0};

      reset = 1'b1;
      mem_clear = 1'b1;
      idle();
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      mem_clear = 1'b0;

      @(negedge clk);
      chk("reset stall", 32'(stall), 32'd0);
      chk("reset fault", 32'(access_fault), 32'd0);
      chk("reset count", 32'(misalign_count), 32'd0);
      chk("reset mem_write", 32'(mem_write), 32'd0);
      @(posedge clk); #1;

      for (int i = 0; i < 14; i++) begin
         drive(vecs[i].rd, vecs[i].wr, vecs[i].mode, vecs[i].addr, vecs[i].wdata);
         @(negedge clk);
         chk($sformatf("vec%0d stall", i), 32'(stall), 32'd0);
         chk($sformatf("vec%0d fault", i), 32'(access_fault), 32'(vecs[i].exp_fault));
         chk($sformatf("vec%0d mem_read", i), 32'(mem_read), 32'(vecs[i].exp_rd));
         chk($sformatf("vec%0d mem_write", i), 32'(mem_write), 32'(vecs[i].exp_wr));
         if (vecs[i].chk_ld) chk($sformatf("vec%0d load_data", i), load_data, vecs[i].exp_ld);
         @(posedge clk); #1;
      end
      idle();
      @(negedge clk);
      chk("aligned count", 32'(misalign_count), 32'd0);
      @(posedge clk); #1;

      run_split(1'b0, 1'b1, MODE_SW, 32'h05, 32'h11223344, 4, 1'b0, 32'h0, "sw@5");
      chk("sw@5 bytes", {mem[8], mem[7], mem[6], mem[5]}, 32'h11223344);
      run_split(1'b1, 1'b0, MODE_LW, 32'h05, 32'h0, 4, 1'b1, 32'h11223344, "lw@5");
      chk("count after word pair", 32'(misalign_count), 32'd2);

      single(1'b0, 1'b1, MODE_SB, 32'h09, 32'h80);
      single(1'b0, 1'b1, MODE_SB, 32'h0A, 32'hFF);
      run_split(1'b1, 1'b0, MODE_LH,  32'h09, 32'h0, 2, 1'b1, 32'hFFFFFF80, "lh@9");
      run_split(1'b1, 1'b0, MODE_LHU, 32'h09, 32'h0, 2, 1'b1, 32'h0000FF80, "lhu@9");
      run_split(1'b0, 1'b1, MODE_SH,  32'h11, 32'h0000ABCD, 2, 1'b0, 32'h0, "sh@11");
      chk("sh@11 bytes", {16'h0, mem[18], mem[17]}, 32'h0000ABCD);
      run_split(1'b1, 1'b0, MODE_LHU, 32'h11, 32'h0, 2, 1'b1, 32'h0000ABCD, "lhu@11");
      chk("count after halves", 32'(misalign_count), 32'd6);

      single(1'b0, 1'b1, MODE_SW, 32'h00, 32'h0);
      single(1'b0, 1'b1, MODE_SW, 32'h04, 32'h0);
      drive(1'b0, 1'b1, MODE_SW, 32'h01, 32'hA1B2C3D4);
      @(negedge clk);
      chk("rst seq byte0 addr", mem_addr, 32'h1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("rst seq byte1 addr", mem_addr, 32'h2);
      chk("rst seq byte1 stall", 32'(stall), 32'd1);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      idle();
      @(negedge clk);
      chk("rst seq stall", 32'(stall), 32'd0);
      chk("rst seq count", 32'(misalign_count), 32'd0);
      chk("rst seq bytes", {mem[4], mem[3], mem[2], mem[1]}, 32'h0000C3D4);
      @(posedge clk); #1;

      @(negedge clk);
      force dut.misalign_count = 16'hFFFE;
      #1;
      release dut.misalign_count;
      @(posedge clk); #1;
      run_split(1'b1, 1'b0, MODE_LHU, 32'h09, 32'h0, 2, 1'b1, 32'h0000FF80, "sat1");
      chk("sat count 1", 32'(misalign_count), 32'h0000FFFF);
      run_split(1'b1, 1'b0, MODE_LH, 32'h09, 32'h0, 2, 1'b1, 32'hFFFFFF80, "sat2");
      run_split(1'b0, 1'b1, MODE_SH, 32'h13, 32'h00001234, 2, 1'b0, 32'h0, "sat3");
      chk("sat count 3", 32'(misalign_count), 32'h0000FFFF);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
